// File: rtl/lpddr5_rw_arbiter.sv
// Read/write command scheduler for an LPDDR5 controller: write-drain watermarks,
// bus turnaround gaps, starvation guards and refresh precedence.
module lpddr5_rw_arbiter #(
  parameter int ADDR_WIDTH   = 18,
  parameter int QDEPTH       = 16,
  parameter int WR_HIGH_WM   = 12,
  parameter int WR_LOW_WM    = 4,
  parameter int STARVE_LIMIT = 32,
  parameter int T_RTW        = 6,
  parameter int T_WTR        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_req,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_ack,
  input  logic                      wr_req,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [$clog2(QDEPTH):0]   wr_count,
  output logic                      wr_ack,
  input  logic                      ref_req,
  output logic                      ref_ack,
  output logic                      iss_valid,
  output logic [1:0]                iss_cmd,
  output logic [ADDR_WIDTH-1:0]     iss_addr,
  input  logic                      iss_ready,
  output logic                      wr_mode
);
  localparam int WCW  = $clog2(QDEPTH) + 1;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam int TMAX = (T_RTW > T_WTR) ? T_RTW : T_WTR;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [WCW-1:0] HI_WM = WCW'(WR_HIGH_WM);
  localparam logic [WCW-1:0] LO_WM = WCW'(WR_LOW_WM);
  localparam logic [SW-1:0]  SLIM  = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0]  TRTW  = TW'(T_RTW);
  localparam logic [TW-1:0]  TWTR  = TW'(T_WTR);

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;
  localparam logic [1:0] CMD_REF  = 2'b11;

  typedef enum logic [2:0] {S_READ, S_WRITE, S_RTW, S_WTR, S_REF} state_e;

  state_e                state_q, state_d;
  logic                  ret_mode_q, ret_mode_d;
  logic [TW-1:0]         turn_cnt_q, turn_cnt_d;
  logic [SW-1:0]         wr_starve_q, wr_starve_d;
  logic [SW-1:0]         rd_starve_q, rd_starve_d;
  logic                  iss_valid_q, iss_valid_d;
  logic [1:0]            iss_cmd_q, iss_cmd_d;
  logic [ADDR_WIDTH-1:0] iss_addr_q, iss_addr_d;
  logic                  wr_mode_q, wr_mode_d;
  logic                  hs, rd_sw, wr_sw;

  assign hs    = iss_valid_q && iss_ready;
  assign rd_sw = (wr_count >= HI_WM) || (!rd_req && wr_req) || (wr_starve_q == SLIM);
  assign wr_sw = (!wr_req && rd_req) || ((wr_count <= LO_WM) && rd_req) ||
                 ((rd_starve_q == SLIM) && (wr_count < HI_WM));

  always_comb begin
    state_d     = state_q;
    ret_mode_d  = ret_mode_q;
    turn_cnt_d  = turn_cnt_q;
    wr_starve_d = wr_starve_q;
    rd_starve_d = rd_starve_q;
    iss_valid_d = iss_valid_q;
    iss_cmd_d   = iss_cmd_q;
    iss_addr_d  = iss_addr_q;

    if (state_q == S_READ && wr_req && wr_starve_q != SLIM) wr_starve_d = wr_starve_q + SW'(1);
    if (state_q == S_WRITE && rd_req && rd_starve_q != SLIM) rd_starve_d = rd_starve_q + SW'(1);

    if (hs) begin
      iss_valid_d = 1'b0;
      iss_cmd_d   = CMD_NONE;
      iss_addr_d  = '0;
      if (iss_cmd_q == CMD_REF) state_d = ret_mode_q ? S_WRITE : S_READ;
    end else if (!iss_valid_q) begin
      // Decisions only while nothing is presented, so a command is never withdrawn.
      unique case (state_q)
        S_READ: begin
          if (ref_req) begin
            ret_mode_d = 1'b0; state_d = S_REF;
            iss_valid_d = 1'b1; iss_cmd_d = CMD_REF; iss_addr_d = '0;
          end else if (rd_sw) begin
            state_d = S_RTW; turn_cnt_d = TRTW;
          end else if (rd_req) begin
            iss_valid_d = 1'b1; iss_cmd_d = CMD_RD; iss_addr_d = rd_addr;
          end
        end
        S_WRITE: begin
          if (ref_req) begin
            ret_mode_d = 1'b1; state_d = S_REF;
            iss_valid_d = 1'b1; iss_cmd_d = CMD_REF; iss_addr_d = '0;
          end else if (wr_sw) begin
            state_d = S_WTR; turn_cnt_d = TWTR;
          end else if (wr_req) begin
            iss_valid_d = 1'b1; iss_cmd_d = CMD_WR; iss_addr_d = wr_addr;
          end
        end
        // Counter is loaded with T and the state is left as it steps to 0: T cycles in TURN.
        S_RTW: begin
          turn_cnt_d = turn_cnt_q - TW'(1);
          if (turn_cnt_q <= TW'(1)) begin state_d = S_WRITE; turn_cnt_d = '0; end
        end
        S_WTR: begin
          turn_cnt_d = turn_cnt_q - TW'(1);
          if (turn_cnt_q <= TW'(1)) begin state_d = S_READ; turn_cnt_d = '0; end
        end
        default: ;
      endcase
    end

    if (state_d == S_WRITE && state_q != S_WRITE) wr_starve_d = '0;
    if (state_d == S_READ && state_q != S_READ)   rd_starve_d = '0;

    wr_mode_d = (state_d == S_WRITE) || (state_d == S_WTR) || (state_d == S_REF && ret_mode_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_READ;
      ret_mode_q  <= 1'b0;
      turn_cnt_q  <= '0;
      wr_starve_q <= '0;
      rd_starve_q <= '0;
      iss_valid_q <= 1'b0;
      iss_cmd_q   <= CMD_NONE;
      iss_addr_q  <= '0;
      wr_mode_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_mode_q  <= ret_mode_d;
      turn_cnt_q  <= turn_cnt_d;
      wr_starve_q <= wr_starve_d;
      rd_starve_q <= rd_starve_d;
      iss_valid_q <= iss_valid_d;
      iss_cmd_q   <= iss_cmd_d;
      iss_addr_q  <= iss_addr_d;
      wr_mode_q   <= wr_mode_d;
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_cmd   = iss_cmd_q;
  assign iss_addr  = iss_addr_q;
  assign wr_mode   = wr_mode_q;
  assign rd_ack    = hs && (iss_cmd_q == CMD_RD);
  assign wr_ack    = hs && (iss_cmd_q == CMD_WR);
  assign ref_ack   = hs && (iss_cmd_q == CMD_REF);
endmodule

// File: tb/tb_lpddr5_rw_arbiter.sv
// Randomized scoreboard bench for lpddr5_rw_arbiter against a transaction-level
// reference model of the scheduling rules.
module tb_lpddr5_rw_arbiter;
  localparam int AW = 18, QD = 16, HI = 12, LO = 4, LIM = 32, TRTW = 6, TWTR = 8;
  localparam int WCW = $clog2(QD) + 1;
  localparam int ST_RD = 0, ST_WR = 1, ST_RTW = 2, ST_WTR = 3, ST_REF = 4;

  logic clk, rst;
  logic rd_req, wr_req, ref_req, iss_ready;
  logic [AW-1:0] rd_addr, wr_addr, iss_addr;
  logic [WCW-1:0] wr_count;
  logic rd_ack, wr_ack, ref_ack, iss_valid, wr_mode;
  logic [1:0] iss_cmd;

  lpddr5_rw_arbiter #(.ADDR_WIDTH(AW), .QDEPTH(QD), .WR_HIGH_WM(HI), .WR_LOW_WM(LO),
    .STARVE_LIMIT(LIM), .T_RTW(TRTW), .T_WTR(TWTR)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_count(wr_count), .wr_ack(wr_ack),
    .ref_req(ref_req), .ref_ack(ref_ack), .iss_valid(iss_valid), .iss_cmd(iss_cmd),
    .iss_addr(iss_addr), .iss_ready(iss_ready), .wr_mode(wr_mode));

  typedef struct { int cyc; logic [1:0] cmd; logic [AW-1:0] addr; } exp_t;
  exp_t expq[$];
  logic [AW-1:0] rdq[$], wrq[$];
  int cyc = 0, errors = 0, checks = 0;
  int p_rd = 0, p_wr = 0, p_ready = 0, p_ref = 0, rd_cap = 16, wr_cap = 16;
  bit ref_clear = 0;

  // Reference model: mode, turnaround end time, starvation ages, presented command.
  int m_state = ST_RD, m_ret = 0, m_wst = 0, m_rsv = 0, turn_exit = 0;
  bit m_valid = 0, m_wrmode = 0;
  logic [1:0] m_cmd = 0;
  logic [AW-1:0] m_addr = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, got, want);
    end
  endtask

  task automatic present(input logic [1:0] c, input logic [AW-1:0] a);
    m_valid = 1; m_cmd = c; m_addr = a;
  endtask

  task automatic model_step();
    int prev, wst_n, rsv_n;
    if (rst) begin
      m_state = ST_RD; m_ret = 0; m_wst = 0; m_rsv = 0; m_valid = 0; m_cmd = 0; m_addr = 0;
      m_wrmode = 0;
      return;
    end
    prev = m_state; wst_n = m_wst; rsv_n = m_rsv;
    if (m_state == ST_RD && wr_req) wst_n = (m_wst < LIM) ? m_wst + 1 : LIM;
    if (m_state == ST_WR && rd_req) rsv_n = (m_rsv < LIM) ? m_rsv + 1 : LIM;
    if (m_valid && iss_ready) begin
      m_valid = 0;
      if (m_cmd == 2'b01) void'(rdq.pop_front());
      else if (m_cmd == 2'b10) void'(wrq.pop_front());
      else begin ref_clear = 1; m_state = m_ret ? ST_WR : ST_RD; end
    end else if (!m_valid) begin
      if (m_state == ST_RD) begin
        if (ref_req) begin m_ret = 0; m_state = ST_REF; present(2'b11, '0); end
        else if (int'(wr_count) >= HI || (!rd_req && wr_req) || m_wst == LIM) begin
          m_state = ST_RTW; turn_exit = cyc + 1 + TRTW;
        end else if (rd_req) present(2'b01, rd_addr);
      end else if (m_state == ST_WR) begin
        if (ref_req) begin m_ret = 1; m_state = ST_REF; present(2'b11, '0); end
        else if ((!wr_req && rd_req) || (int'(wr_count) <= LO && rd_req) ||
                 (m_rsv == LIM && int'(wr_count) < HI)) begin
          m_state = ST_WTR; turn_exit = cyc + 1 + TWTR;
        end else if (wr_req) present(2'b10, wr_addr);
      end else if (m_state == ST_RTW && cyc + 1 == turn_exit) m_state = ST_WR;
      else if (m_state == ST_WTR && cyc + 1 == turn_exit) m_state = ST_RD;
    end
    if (m_state == ST_WR && prev != ST_WR) wst_n = 0;
    if (m_state == ST_RD && prev != ST_RD) rsv_n = 0;
    m_wst = wst_n; m_rsv = rsv_n;
    m_wrmode = (m_state == ST_WR) || (m_state == ST_WTR) || (m_state == ST_REF && m_ret == 1);
  endtask

  task automatic drive();
    if (ref_clear) begin ref_req = 0; ref_clear = 0; end
    if (!ref_req && int'($urandom_range(999)) < p_ref) ref_req = 1;
    if (int'($urandom_range(99)) < p_rd && rdq.size() < rd_cap) rdq.push_back(AW'($urandom));
    if (int'($urandom_range(99)) < p_wr && wrq.size() < wr_cap) wrq.push_back(AW'($urandom));
    rd_req = rdq.size() != 0; rd_addr = rd_req ? rdq[0] : '0;
    wr_req = wrq.size() != 0; wr_addr = wr_req ? wrq[0] : '0;
    wr_count = WCW'(wrq.size());
    iss_ready = !rst && (int'($urandom_range(99)) < p_ready);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    drive();
    if (!rst && m_valid && iss_ready) expq.push_back('{cyc, m_cmd, m_addr});
  endtask

  // Monitor: pops the scoreboard on every DUT handshake, checks hold-stability and mode.
  initial begin
    bit prev_stall = 0;
    logic [1:0] pc = 0;
    logic [AW-1:0] pa = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_iss_valid", 32'(iss_valid), 0);
        check("rst_iss_cmd", 32'(iss_cmd), 0);
        check("rst_iss_addr", 32'(iss_addr), 0);
        check("rst_acks", 32'({rd_ack, wr_ack, ref_ack}), 0);
        check("rst_wr_mode", 32'(wr_mode), 0);
        prev_stall = 0;
      end else begin
        if (prev_stall) check("stall_hold", 32'({iss_valid, iss_cmd, iss_addr}), 32'({1'b1, pc, pa}));
        prev_stall = iss_valid && !iss_ready; pc = iss_cmd; pa = iss_addr;
        if (iss_valid && iss_ready) begin
          check("hs_expected", 32'(expq.size() != 0), 1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            check("hs_cycle", 32'(cyc), 32'(e.cyc));
            check("hs_cmd", 32'(iss_cmd), 32'(e.cmd));
            check("hs_addr", 32'(iss_addr), 32'(e.addr));
            check("hs_acks", 32'({rd_ack, wr_ack, ref_ack}),
                  32'({e.cmd == 2'b01, e.cmd == 2'b10, e.cmd == 2'b11}));
          end
        end else begin
          check("idle_acks", 32'({rd_ack, wr_ack, ref_ack}), 0);
          if (expq.size() != 0 && expq[0].cyc <= cyc) begin
            check("hs_missed", 32'(iss_valid && iss_ready), 1);
            void'(expq.pop_front());
          end
        end
        check("wr_mode", 32'(wr_mode), 32'(m_wrmode));
      end
    end
  end

  initial begin
    bit found = 0;
    rst = 0; rd_req = 0; wr_req = 0; ref_req = 0; iss_ready = 0;
    rd_addr = '0; wr_addr = '0; wr_count = '0;
    #1 rst = 1;
    rdq.push_back(18'h10); rdq.push_back(18'h11); rdq.push_back(18'h12); rdq.push_back(18'h13);
    repeat (3) cycle();
    rst = 0;
    // Reads only: four back-to-back RDs.
    p_ready = 100;
    repeat (12) cycle();
    // Watermark drain, then fall back toward the low watermark.
    p_rd = 50; p_wr = 90;
    repeat (60) cycle();
    p_wr = 0; p_rd = 80;
    repeat (80) cycle();
    // Starvation: reads always pending, only two writes queued.
    p_rd = 0; repeat (60) cycle();
    wr_cap = 2; p_wr = 100; p_rd = 100;
    repeat (120) cycle();
    // Refresh under heavy backpressure.
    wr_cap = 16; p_rd = 40; p_wr = 40; p_ready = 30; p_ref = 30;
    repeat (300) cycle();
    // Random mix with shifting knobs.
    for (int k = 0; k < 15; k++) begin
      p_rd = $urandom_range(100); p_wr = $urandom_range(100);
      p_ready = $urandom_range(10, 100); p_ref = $urandom_range(20);
      repeat (100) cycle();
    end
    // Reset while a WR is presented and stalled.
    p_rd = 30; p_wr = 90; p_ready = 50; p_ref = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      cycle();
      if (m_valid && m_state == ST_WR && !iss_ready) found = 1;
    end
    check("rst_wait_wr_presented", 32'(found), 1);
    if (found) begin
      rst = 1;
      cycle(); cycle();
      rst = 0;
    end
    p_ready = 70; repeat (100) cycle();
    // Drain everything.
    p_rd = 0; p_wr = 0; p_ready = 100;
    repeat (300) cycle();
    @(negedge clk); #1;
    check("scoreboard_drained", 32'(expq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lpddr5_rw_arbiter.md
Name: lpddr5_rw_arbiter

Overview:
Scheduler between the controller's read and write command queues and the DRAM command issuer. It picks which queue head to issue and runs a write-drain policy with high/low watermarks. It inserts read-to-write and write-to-read bus turnaround gaps and gives refresh requests precedence. It pops a queue only on a completed issue handshake. It sits between the rd/wr command queues and the DRAM command sequencer.

Parameters:
ADDR_WIDTH, 18, width of queued command address
QDEPTH, 16, write queue depth; wr_count range 0..QDEPTH
WR_HIGH_WM, 12, wr_count at or above which write drain is forced
WR_LOW_WM, 4, wr_count at or below which write drain may end
STARVE_LIMIT, 32, pending cycles after which the idle direction is forced
T_RTW, 6, turnaround cycles for read->write
T_WTR, 8, turnaround cycles for write->read

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rd_req  in  1  read queue non-empty
rd_addr  in  ADDR_WIDTH  read queue head address
rd_ack  out  1  pop read queue (1-cycle pulse)
wr_req  in  1  write queue non-empty
wr_addr  in  ADDR_WIDTH  write queue head address
wr_count  in  $clog2(QDEPTH)+1  write queue occupancy
wr_ack  out  1  pop write queue (1-cycle pulse)
ref_req  in  1  refresh due (level, held until ref_ack)
ref_ack  out  1  refresh issued (1-cycle pulse)
iss_valid  out  1  command presented to issuer
iss_cmd  out  2  00 NONE, 01 RD, 10 WR, 11 REF
iss_addr  out  ADDR_WIDTH  address of presented command (0 for REF)
iss_ready  in  1  issuer accepts
wr_mode  out  1  1 while in WRITE_MODE or TURN_WTR

Behaviour:
- Reset (async, immediate): state READ_MODE. iss_valid=0, iss_cmd=NONE, iss_addr=0, rd_ack=wr_ack=ref_ack=0, wr_mode=0. All counters are 0. Reset mid-handshake drops the command with no ack, so the queue keeps the entry.
- States: READ_MODE, WRITE_MODE, TURN_RTW, TURN_WTR, REFRESH. A 1-bit ret_mode records the mode that was interrupted by refresh.
- Handshake occurs in a cycle with iss_valid&&iss_ready. In that same cycle the matching rd_ack, wr_ack or ref_ack is 1. The next cycle iss_valid=0. iss_valid, iss_cmd and iss_addr hold stable while iss_valid=1 and iss_ready=0.
- Issue in READ_MODE: if iss_valid=0, rd_req=1 and no refresh or switch is taken this cycle, the block registers iss_valid=1, RD, rd_addr. Latency is 1 cycle. Maximum rate is 1 issue per 2 cycles. WRITE_MODE works symmetrically with wr_req and wr_addr.
- Decisions (refresh, mode switch) are evaluated only when iss_valid=0. A presented command is never withdrawn.
- Priority each decision cycle: refresh > mode switch > issue.
- Refresh: if ref_req=1, set ret_mode and go to REFRESH. Present REF on the next cycle. On the handshake, pulse ref_ack and return to ret_mode with no turnaround.
- READ_MODE to TURN_RTW when any of:
  - wr_count>=WR_HIGH_WM;
  - rd_req=0 and wr_req=1;
  - wr_starve==STARVE_LIMIT.
- WRITE_MODE to TURN_WTR when any of:
  - wr_req=0 and rd_req=1;
  - wr_count<=WR_LOW_WM and rd_req=1;
  - rd_starve==STARVE_LIMIT and wr_count<WR_HIGH_WM.
- With both queues empty, the current mode is held.
- Turnaround: a down-counter is loaded with T_RTW or T_WTR on entry. The state exits when the count reaches 0, giving exactly T cycles in the TURN state. Exit goes to WRITE_MODE or READ_MODE respectively. No command is issued during turnaround. A ref_req arriving during turnaround is served after entry to the new mode.
- Starvation counters:
  - wr_starve increments each READ_MODE cycle with wr_req=1 and saturates at STARVE_LIMIT.
  - rd_starve increments each WRITE_MODE cycle with rd_req=1 and saturates at STARVE_LIMIT.
  - Each clears on entry to the mode it protects.
  - Width is $clog2(STARVE_LIMIT+1).
- wr_mode is registered and equals 1 in WRITE_MODE and TURN_WTR, and during REFRESH when ret_mode=write.
- Simultaneous rd_req/wr_req rises while idle in READ_MODE: RD is issued unless a switch condition holds.

Test Plan:
- Reads only: rd_req=1 for 4 handshakes with iss_ready=1 and rd_addr 0x10..0x13 -> RD presented at cycles 1,3,5,7 with those addresses; 4 rd_ack pulses; wr_mode=0.
- Watermark: READ_MODE with rd_req=1, wr_count raised to 12 -> after the current handshake, TURN_RTW for 6 cycles, then WR issues. Drain continues while wr_count>4. At wr_count=4 with rd_req=1 -> TURN_WTR for 8 cycles, then RD.
- Starvation: rd_req=1 continuously, wr_req=1 and wr_count=2 -> the switch to write occurs once wr_starve reaches 32 (about 32 cycles after wr_req rises); the first WR is presented 6 turnaround cycles later.
- Refresh preemption: ref_req rises while RD is presented with iss_ready=0 for 3 cycles -> RD held stable and completed with rd_ack; next REF with ref_ack on handshake; then return to READ_MODE with no gap.
- Backpressure: WR presented with iss_ready=0 for 5 cycles -> iss_valid, iss_cmd and iss_addr constant; wr_ack only on the accept cycle.
- Reset mid-operation: assert rst while iss_valid=1 (TURN or WRITE_MODE) -> next sample shows all outputs at reset values, state READ_MODE, and no ack pulse.
